// File: rtl/dmi_pkg.sv
// Shared DMI definitions: command codes, bus widths, responder FSM states
// and the byte-masked write merge.
package dmi_pkg;

  localparam int unsigned DMI_ADDR_W = 29;
  localparam int unsigned DMI_DATA_W = 256;
  localparam int unsigned DMI_MASK_W = 32;

  localparam logic [2:0] DMI_CMD_WR = 3'b000;
  localparam logic [2:0] DMI_CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_IDLE,
    ST_WR_WAIT,
    ST_REFRESH,
    ST_SELFREF
  } dmi_state_e;

  // A set mask bit protects the corresponding byte of the old word.
  function automatic logic [DMI_DATA_W-1:0] dmi_merge(
    input logic [DMI_DATA_W-1:0] old_word,
    input logic [DMI_DATA_W-1:0] new_word,
    input logic [DMI_MASK_W-1:0] mask
  );
    logic [DMI_DATA_W-1:0] w;
    w = old_word;
    for (int unsigned b = 0; b < DMI_MASK_W; b++) begin
      if (!mask[b]) w[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dmi_responder_model_if.sv
// DMI initiator/responder bus bundle; the responder uses the slave modport.
interface dmi_responder_model_if;
  import dmi_pkg::*;

  logic [2:0]            dmi_cmd;
  logic                  dmi_cmd_en;
  logic [DMI_ADDR_W-1:0] dmi_addr;
  logic [DMI_DATA_W-1:0] dmi_wr_data;
  logic                  dmi_wr_data_en;
  logic                  dmi_wr_data_end;
  logic [DMI_MASK_W-1:0] dmi_wr_data_mask;
  logic                  dmi_sr_req;
  logic                  dmi_ref_req;
  logic                  dmi_burst;
  logic                  dmi_init_calib_complete;
  logic                  dmi_cmd_ready;
  logic                  dmi_wr_data_rdy;
  logic [DMI_DATA_W-1:0] dmi_rd_data;
  logic                  dmi_rd_data_valid;
  logic                  dmi_rd_data_end;
  logic                  dmi_sr_ack;
  logic                  dmi_ref_ack;
  logic                  dmi_pll_stop;
  logic                  dmi_clk_out;
  logic                  dmi_ddr_rst;

  modport slave (
    input  dmi_cmd, dmi_cmd_en, dmi_addr, dmi_wr_data, dmi_wr_data_en,
           dmi_wr_data_end, dmi_wr_data_mask, dmi_sr_req, dmi_ref_req, dmi_burst,
    output dmi_init_calib_complete, dmi_cmd_ready, dmi_wr_data_rdy, dmi_rd_data,
           dmi_rd_data_valid, dmi_rd_data_end, dmi_sr_ack, dmi_ref_ack,
           dmi_pll_stop, dmi_clk_out, dmi_ddr_rst
  );

  modport master (
    output dmi_cmd, dmi_cmd_en, dmi_addr, dmi_wr_data, dmi_wr_data_en,
           dmi_wr_data_end, dmi_wr_data_mask, dmi_sr_req, dmi_ref_req, dmi_burst,
    input  dmi_init_calib_complete, dmi_cmd_ready, dmi_wr_data_rdy, dmi_rd_data,
           dmi_rd_data_valid, dmi_rd_data_end, dmi_sr_ack, dmi_ref_ack,
           dmi_pll_stop, dmi_clk_out, dmi_ddr_rst
  );

endinterface

// File: rtl/dmi_rd_delay.sv
// Read latency line: valid/data shift register, RD_LAT stages deep.
module dmi_rd_delay
  import dmi_pkg::*;
#(
  parameter int unsigned RD_LAT = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DMI_DATA_W-1:0] in_data,
  output logic                  out_valid,
  output logic [DMI_DATA_W-1:0] out_data,
  output logic                  busy
);

  logic [RD_LAT-1:0]     valid_q, valid_d;
  logic [DMI_DATA_W-1:0] data_q [RD_LAT];
  logic [DMI_DATA_W-1:0] data_d [RD_LAT];

  always_comb begin
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_data  = out_valid ? data_q[RD_LAT-1] : '0;
  assign busy      = |valid_q;

endmodule

// File: rtl/dmi_responder_model.sv
// Behavioural DMI memory responder: calibration, single-beat reads/writes,
// refresh and self-refresh handling over a DEPTH x 256-bit memory.
module dmi_responder_model
  import dmi_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned RD_LAT       = 4,
  parameter int unsigned REF_CYCLES   = 8
) (
  input logic                  clock,
  input logic                  reset_n,
  input logic                  dmi_rst_n,
  dmi_responder_model_if.slave dmi
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REF_LAST   = CNT_W'(REF_CYCLES - 1);

  logic                  rst_n;
  dmi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  calib_done_q, calib_done_d;
  logic                  ref_pend_q, ref_pend_d;
  logic                  ref_ack_q, ref_ack_d;
  logic                  sr_ack_q, sr_ack_d;
  logic                  ddr_rst_q, ddr_rst_d;
  logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
  logic [DMI_DATA_W-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  ref_want;
  logic                  cmd_ready, wr_rdy;
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DMI_DATA_W-1:0] mem_wdata;
  logic                  rd_push, rd_busy, rd_valid;
  logic [DMI_DATA_W-1:0] rd_word, rd_data;
  logic                  unused_ok;

  assign rst_n     = reset_n & dmi_rst_n;
  assign idx       = dmi.dmi_addr[5 +: IDX_W];
  assign ref_want  = ref_pend_q | dmi.dmi_ref_req;
  assign rd_word   = mem_q[idx];
  assign unused_ok = ^{dmi.dmi_burst, dmi.dmi_addr};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    calib_done_d = calib_done_q;
    ref_pend_d   = ref_want;
    ref_ack_d    = 1'b0;
    wr_idx_d     = wr_idx_q;
    mem_we       = 1'b0;
    mem_widx     = wr_idx_q;
    rd_push      = 1'b0;
    cmd_ready    = 1'b0;
    wr_rdy       = 1'b0;

    unique case (state_q)
      ST_CALIB: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CALIB_LAST) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          calib_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        // Refresh beats self-refresh beats commands; all wait for the read line to drain.
        if (!rd_busy) begin
          if (ref_want) begin
            state_d    = ST_REFRESH;
            cnt_d      = '0;
            ref_pend_d = 1'b0;
          end else if (dmi.dmi_sr_req) begin
            state_d = ST_SELFREF;
          end else begin
            cmd_ready = 1'b1;
            wr_rdy    = dmi.dmi_cmd_en && (dmi.dmi_cmd == DMI_CMD_WR);
            if (dmi.dmi_cmd_en) begin
              if (dmi.dmi_cmd == DMI_CMD_RD) begin
                rd_push = 1'b1;
              end else if (dmi.dmi_cmd == DMI_CMD_WR) begin
                wr_idx_d = idx;
                mem_widx = idx;
                if (dmi.dmi_wr_data_en && dmi.dmi_wr_data_end) mem_we  = 1'b1;
                else                                           state_d = ST_WR_WAIT;
              end
            end
          end
        end
      end
      ST_WR_WAIT: begin
        wr_rdy = 1'b1;
        if (dmi.dmi_wr_data_en && dmi.dmi_wr_data_end) begin
          mem_we  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_REFRESH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == REF_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          ref_ack_d = 1'b1;
        end
      end
      ST_SELFREF: begin
        if (!dmi.dmi_sr_req) state_d = ST_IDLE;
      end
      default: state_d = ST_CALIB;
    endcase

    sr_ack_d  = (state_d == ST_SELFREF);
    ddr_rst_d = !rst_n;
    mem_wdata = dmi_merge(mem_q[mem_widx], dmi.dmi_wr_data, dmi.dmi_wr_data_mask);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q      <= ST_CALIB;
      cnt_q        <= '0;
      calib_done_q <= 1'b0;
      ref_pend_q   <= 1'b0;
      ref_ack_q    <= 1'b0;
      sr_ack_q     <= 1'b0;
      wr_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      calib_done_q <= calib_done_d;
      ref_pend_q   <= ref_pend_d;
      ref_ack_q    <= ref_ack_d;
      sr_ack_q     <= sr_ack_d;
      wr_idx_q     <= wr_idx_d;
    end
    ddr_rst_q <= ddr_rst_d;
  end

  // Memory has no reset so contents survive it; a reset cycle still blocks the write.
  always_ff @(posedge clock) begin
    if (rst_n && mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  dmi_rd_delay #(
    .RD_LAT (RD_LAT)
  ) u_rd_delay (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (rd_push),
    .in_data   (rd_word),
    .out_valid (rd_valid),
    .out_data  (rd_data),
    .busy      (rd_busy)
  );

  assign dmi.dmi_init_calib_complete = calib_done_q;
  assign dmi.dmi_cmd_ready           = cmd_ready;
  assign dmi.dmi_wr_data_rdy         = wr_rdy;
  assign dmi.dmi_rd_data             = rd_data;
  assign dmi.dmi_rd_data_valid       = rd_valid;
  assign dmi.dmi_rd_data_end         = rd_valid;
  assign dmi.dmi_sr_ack              = sr_ack_q;
  assign dmi.dmi_ref_ack             = ref_ack_q;
  assign dmi.dmi_pll_stop            = 1'b0;
  assign dmi.dmi_clk_out             = clock;
  assign dmi.dmi_ddr_rst             = ddr_rst_q;

endmodule

// File: tb/tb_dmi_responder_model.sv
// Table-driven bench for dmi_responder_model with a read-response scoreboard.
module tb_dmi_responder_model;
  import dmi_pkg::*;

  localparam int DEPTH   = 1024;
  localparam int CALIB   = 64;
  localparam int RD_LAT  = 4;
  localparam int REF_CYC = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dmi_rst_n = 1'b1;
  always #5 clk = ~clk;

  dmi_responder_model_if bus ();

  dmi_responder_model #(
    .DEPTH        (DEPTH),
    .CALIB_CYCLES (CALIB),
    .RD_LAT       (RD_LAT),
    .REF_CYCLES   (REF_CYC)
  ) dut (
    .clock     (clk),
    .reset_n   (reset_n),
    .dmi_rst_n (dmi_rst_n),
    .dmi       (bus)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [255:0] data;
    int           due;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  typedef enum {K_WR_SAME, K_WR_SPLIT, K_RD, K_STRAY, K_ILL} kind_e;
  typedef struct {
    kind_e        kind;
    logic [28:0]  addr;
    logic [255:0] data;
    logic [31:0]  mask;
    logic [255:0] exp_data;
  } vec_t;
  vec_t vecs[14];

  task automatic chk_bit(input string name, input logic got, input logic exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk_word(input string name, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard: every read beat must match the oldest expected entry, on its due cycle.
  always @(negedge clk) begin
    rd_exp_t e;
    if (bus.dmi_rd_data_valid === 1'b1 || bus.dmi_rd_data_end === 1'b1) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_rd: valid %b end %b at cycle %0d, none expected",
                 bus.dmi_rd_data_valid, bus.dmi_rd_data_end, cyc);
      end else begin
        e = exp_q.pop_front();
        chk_word("rd_data", bus.dmi_rd_data, e.data);
        chk_bit("rd_valid", bus.dmi_rd_data_valid, 1'b1);
        chk_bit("rd_end", bus.dmi_rd_data_end, 1'b1);
        chk_int("rd_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dmi_cmd          = DMI_CMD_WR;
    bus.dmi_cmd_en       = 1'b0;
    bus.dmi_addr         = '0;
    bus.dmi_wr_data      = '0;
    bus.dmi_wr_data_en   = 1'b0;
    bus.dmi_wr_data_end  = 1'b0;
    bus.dmi_wr_data_mask = '0;
    bus.dmi_sr_req       = 1'b0;
    bus.dmi_ref_req      = 1'b0;
    bus.dmi_burst        = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    #1;
    while (bus.dmi_cmd_ready !== 1'b1 && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk_bit("wait_ready", bus.dmi_cmd_ready, 1'b1);
  endtask

  task automatic calib_check();
    int nvalid = 0;
    for (int j = 1; j <= CALIB; j++) begin
      @(posedge clk);
      #2;
      if (bus.dmi_rd_data_valid === 1'b1) nvalid++;
      if (j == 1) chk_bit("ddr_rst_release", bus.dmi_ddr_rst, 1'b0);
      if (j == CALIB - 1) chk_bit("calib_early", bus.dmi_init_calib_complete, 1'b0);
      if (j == CALIB) begin
        chk_bit("calib_done", bus.dmi_init_calib_complete, 1'b1);
        chk_bit("calib_ready", bus.dmi_cmd_ready, 1'b1);
      end
    end
    chk_int("no_valid_after_reset", nvalid, 0);
  endtask

  task automatic apply_reset(input bit use_dmi_rst);
    if (use_dmi_rst) dmi_rst_n = 1'b0;
    else             reset_n   = 1'b0;
    exp_q.delete();
    step();
    idle_inputs();
    step();
    #1;
    chk_bit("rst_calib", bus.dmi_init_calib_complete, 1'b0);
    chk_bit("rst_cmd_ready", bus.dmi_cmd_ready, 1'b0);
    chk_bit("rst_wr_rdy", bus.dmi_wr_data_rdy, 1'b0);
    chk_bit("rst_rd_valid", bus.dmi_rd_data_valid, 1'b0);
    chk_bit("rst_rd_end", bus.dmi_rd_data_end, 1'b0);
    chk_word("rst_rd_data", bus.dmi_rd_data, '0);
    chk_bit("rst_sr_ack", bus.dmi_sr_ack, 1'b0);
    chk_bit("rst_ref_ack", bus.dmi_ref_ack, 1'b0);
    chk_bit("rst_pll_stop", bus.dmi_pll_stop, 1'b0);
    chk_bit("rst_ddr_rst", bus.dmi_ddr_rst, 1'b1);
    chk_bit("clk_out", bus.dmi_clk_out, clk);
    reset_n   = 1'b1;
    dmi_rst_n = 1'b1;
    calib_check();
  endtask

  task automatic do_read(input logic [28:0] addr, input logic [255:0] exp, input bit push,
                         output int c);
    wait_ready();
    c = cyc;
    bus.dmi_cmd    = DMI_CMD_RD;
    bus.dmi_addr   = addr;
    bus.dmi_cmd_en = 1'b1;
    #1;
    chk_bit("rd_accept", bus.dmi_cmd_ready, 1'b1);
    if (push) exp_q.push_back('{data: exp, due: c + RD_LAT});
    step();
    idle_inputs();
    #1;
    chk_bit("rd_inflight_block", bus.dmi_cmd_ready, 1'b0);
  endtask

  task automatic do_write_same(input logic [28:0] addr, input logic [255:0] data,
                               input logic [31:0] mask);
    wait_ready();
    bus.dmi_cmd          = DMI_CMD_WR;
    bus.dmi_addr         = addr;
    bus.dmi_cmd_en       = 1'b1;
    bus.dmi_wr_data      = data;
    bus.dmi_wr_data_mask = mask;
    bus.dmi_wr_data_en   = 1'b1;
    bus.dmi_wr_data_end  = 1'b1;
    #1;
    chk_bit("wr_same_rdy", bus.dmi_wr_data_rdy, 1'b1);
    step();
    idle_inputs();
    #1;
    chk_bit("wr_same_idle", bus.dmi_cmd_ready, 1'b1);
  endtask

  task automatic do_write_split(input logic [28:0] addr, input logic [255:0] data,
                                input logic [31:0] mask);
    wait_ready();
    bus.dmi_cmd    = DMI_CMD_WR;
    bus.dmi_addr   = addr;
    bus.dmi_cmd_en = 1'b1;
    step();
    idle_inputs();
    bus.dmi_wr_data     = ~data;
    bus.dmi_wr_data_en  = 1'b1;
    bus.dmi_wr_data_end = 1'b0;
    #1;
    chk_bit("wr_wait_rdy", bus.dmi_wr_data_rdy, 1'b1);
    chk_bit("wr_wait_block1", bus.dmi_cmd_ready, 1'b0);
    step();
    idle_inputs();
    #1;
    chk_bit("wr_wait_block2", bus.dmi_cmd_ready, 1'b0);
    step();
    bus.dmi_wr_data      = data;
    bus.dmi_wr_data_mask = mask;
    bus.dmi_wr_data_en   = 1'b1;
    bus.dmi_wr_data_end  = 1'b1;
    #1;
    chk_bit("wr_wait_block3", bus.dmi_cmd_ready, 1'b0);
    step();
    idle_inputs();
    #1;
    chk_bit("wr_split_commit", bus.dmi_cmd_ready, 1'b1);
  endtask

  task automatic do_stray(input logic [255:0] data);
    wait_ready();
    bus.dmi_wr_data     = data;
    bus.dmi_wr_data_en  = 1'b1;
    bus.dmi_wr_data_end = 1'b1;
    #1;
    chk_bit("stray_rdy", bus.dmi_wr_data_rdy, 1'b0);
    step();
    idle_inputs();
  endtask

  task automatic do_ill(input logic [28:0] addr);
    wait_ready();
    bus.dmi_cmd    = 3'b101;
    bus.dmi_addr   = addr;
    bus.dmi_cmd_en = 1'b1;
    #1;
    chk_bit("ill_accept", bus.dmi_cmd_ready, 1'b1);
    step();
    idle_inputs();
    #1;
    chk_bit("ill_dropped", bus.dmi_cmd_ready, 1'b1);
  endtask

  function automatic vec_t mk(kind_e k, logic [28:0] a, logic [255:0] d, logic [31:0] m,
                              logic [255:0] e);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.mask = m; v.exp_data = e;
    return v;
  endfunction

  initial begin
    logic [255:0] aa, w2, p, pc;
    int c, nacks;

    aa = {32{8'hAA}};
    w2 = {{31{8'h55}}, 8'hAA};
    p  = {8{32'hDEADBEEF}};
    pc = {{4{32'hDEADBEEF}}, {16{8'hCC}}};

    vecs[0]  = mk(K_WR_SAME,  29'h40,       aa,              32'h0,         '0);
    vecs[1]  = mk(K_RD,       29'h40,       '0,              32'h0,         aa);
    vecs[2]  = mk(K_WR_SAME,  29'h40,       {32{8'h55}},     32'h0000_0001, '0);
    vecs[3]  = mk(K_RD,       29'h40,       '0,              32'h0,         w2);
    vecs[4]  = mk(K_WR_SPLIT, 29'h80,       p,               32'h0,         '0);
    vecs[5]  = mk(K_RD,       29'h80,       '0,              32'h0,         p);
    vecs[6]  = mk(K_STRAY,    29'h0,        {32{8'h11}},     32'h0,         '0);
    vecs[7]  = mk(K_RD,       29'h80,       '0,              32'h0,         p);
    vecs[8]  = mk(K_ILL,      29'h40,       '0,              32'h0,         '0);
    vecs[9]  = mk(K_RD,       29'h5F,       '0,              32'h0,         w2);
    vecs[10] = mk(K_WR_SPLIT, 29'h9F,       {32{8'hCC}},     32'hFFFF_0000, '0);
    vecs[11] = mk(K_RD,       29'h80,       '0,              32'h0,         pc);
    vecs[12] = mk(K_RD,       29'h8040,     '0,              32'h0,         w2);
    vecs[13] = mk(K_RD,       29'h1FFF8040, '0,              32'h0,         w2);

    idle_inputs();
    step();
    apply_reset(1'b0);

    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_WR_SAME:  do_write_same(vecs[i].addr, vecs[i].data, vecs[i].mask);
        K_WR_SPLIT: do_write_split(vecs[i].addr, vecs[i].data, vecs[i].mask);
        K_RD:       do_read(vecs[i].addr, vecs[i].exp_data, 1'b1, c);
        K_STRAY:    do_stray(vecs[i].data);
        K_ILL:      do_ill(vecs[i].addr);
        default:    ;
      endcase
    end

    // Refresh request during a read is deferred until the read line drains.
    do_read(29'h40, w2, 1'b1, c);
    bus.dmi_ref_req = 1'b1;
    step();
    bus.dmi_ref_req = 1'b0;
    while (cyc < c + RD_LAT) step();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk_bit("ref_defer_ready", bus.dmi_cmd_ready, 1'b0);
      chk_bit("ref_ack_early", bus.dmi_ref_ack, 1'b0);
      step();
    end
    #1;
    chk_bit("ref_ack_pulse", bus.dmi_ref_ack, 1'b1);
    step();
    #1;
    chk_bit("ref_ack_single", bus.dmi_ref_ack, 1'b0);

    // Self-refresh held 20 cycles while a read is requested throughout.
    wait_ready();
    nacks = 0;
    for (int k = 0; k < 22; k++) begin
      bus.dmi_sr_req = (k < 20);
      bus.dmi_cmd    = DMI_CMD_RD;
      bus.dmi_addr   = 29'h40;
      bus.dmi_cmd_en = (k < 20);
      #1;
      if (bus.dmi_sr_ack === 1'b1) nacks++;
      if (k <= 20) chk_bit("sr_block_ready", bus.dmi_cmd_ready, 1'b0);
      else begin
        chk_bit("sr_resume_ready", bus.dmi_cmd_ready, 1'b1);
        chk_bit("sr_ack_fall", bus.dmi_sr_ack, 1'b0);
      end
      @(posedge clk);
      #1;
    end
    idle_inputs();
    chk_int("sr_ack_cycles", nacks, 20);

    // reset_n asserted in cycle 2 of a read aborts it.
    do_read(29'h80, pc, 1'b0, c);
    step();
    apply_reset(1'b0);

    // dmi_rst_n in the same cycle as the closing write beat blocks the write.
    wait_ready();
    bus.dmi_cmd    = DMI_CMD_WR;
    bus.dmi_addr   = 29'h40;
    bus.dmi_cmd_en = 1'b1;
    step();
    idle_inputs();
    bus.dmi_wr_data     = {32{8'hEE}};
    bus.dmi_wr_data_en  = 1'b1;
    bus.dmi_wr_data_end = 1'b1;
    #1;
    chk_bit("wr_wait_rdy_before_rst", bus.dmi_wr_data_rdy, 1'b1);
    apply_reset(1'b1);

    do_read(29'h40, w2, 1'b1, c);
    do_read(29'h8040, w2, 1'b1, c);
    do_read(29'h80, pc, 1'b1, c);

    for (int n = 0; n < 20 && exp_q.size() != 0; n++) step();
    chk_int("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
